// File: rtl/color_manager_config_arbiter_pkg.sv
// Shared state encodings and defaults for the Color Manager configuration arbiter.
package color_manager_config_arbiter_pkg;

   localparam int ARB_STATE_WIDTH        = 2;
   localparam int DEFAULT_TIMEOUT_CYCLES = 255;

   typedef enum logic [ARB_STATE_WIDTH-1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } arb_state_t;

   // Width of a requester index; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/color_manager_rr_picker.sv
// Combinational round-robin picker: first active request searching upward from Last+1.
module color_manager_rr_picker
   import color_manager_config_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] Req_Valid,
   input  logic [IDX_W-1:0]   Last,
   output logic [NUM_REQ-1:0] Winner,
   output logic [IDX_W-1:0]   Winner_Idx,
   output logic               Found
);

   logic [IDX_W-1:0] cand;

   // NOTE: every output gets a default first, so no path through this block infers a latch.
   always_comb begin
      Winner     = '0;
      Winner_Idx = '0;
      Found      = 1'b0;
      cand       = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IDX_W'((int'(Last) + k) % NUM_REQ);
         if (!Found && Req_Valid[cand]) begin
            Found        = 1'b1;
            Winner[cand] = 1'b1;
            Winner_Idx   = cand;
         end
      end
   end

endmodule

// File: rtl/color_manager_config_arbiter.sv
// Round-robin arbiter for the Color Manager config bus; one transfer at a time.
// Optional ISSUE timeout is built only when CM_ARB_TIMEOUT_EN is defined.
module color_manager_config_arbiter
   import color_manager_config_arbiter_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int C_ADDR_WIDTH   = 4,
   parameter int C_DATA_WIDTH   = 14,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                             Clk,
   input  logic                             rst_n,
   input  logic [NUM_REQ-1:0]               Req_Valid,
   input  logic [NUM_REQ*C_ADDR_WIDTH-1:0]  Req_Addr,
   input  logic [NUM_REQ*C_DATA_WIDTH-1:0]  Req_Data,
   output logic [NUM_REQ-1:0]               Req_Rdy,
   output logic [C_ADDR_WIDTH-1:0]          C_Addr,
   output logic [C_DATA_WIDTH-1:0]          C_Data,
   output logic                             C_Valid,
   input  logic                             C_Rdy,
   output logic [NUM_REQ-1:0]               Grant,
   output logic                             Busy,
   output logic                             Timeout_Err
);

   localparam int IDX_W = idx_width(NUM_REQ);

   arb_state_t              state, state_n;
   logic [IDX_W-1:0]        last, last_n, owner, owner_n;
   logic [C_ADDR_WIDTH-1:0] c_addr_n;
   logic [C_DATA_WIDTH-1:0] c_data_n;
   logic                    c_valid_n, busy_n, complete;
   logic [NUM_REQ-1:0]      req_rdy_n, grant_n, pick;
   logic [IDX_W-1:0]        pick_idx;
   logic                    pick_found;

   logic [C_ADDR_WIDTH-1:0] req_addr_arr [NUM_REQ];
   logic [C_DATA_WIDTH-1:0] req_data_arr [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign req_addr_arr[i] = Req_Addr[i*C_ADDR_WIDTH +: C_ADDR_WIDTH];
      assign req_data_arr[i] = Req_Data[i*C_DATA_WIDTH +: C_DATA_WIDTH];
   end

   color_manager_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .Req_Valid  (Req_Valid),
      .Last       (last),
      .Winner     (pick),
      .Winner_Idx (pick_idx),
      .Found      (pick_found)
   );

`ifdef CM_ARB_TIMEOUT_EN
   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CNT_W-1:0] wait_cnt, wait_cnt_n;
   logic             timeout_err_n, expired;

   // This cycle's increment would make the count reach TIMEOUT_CYCLES.
   assign expired = (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign Timeout_Err = 1'b0;
`endif

   always_comb begin
      state_n   = state;
      last_n    = last;
      owner_n   = owner;
      c_addr_n  = C_Addr;
      c_data_n  = C_Data;
      c_valid_n = C_Valid;
      grant_n   = Grant;
      busy_n    = Busy;
      req_rdy_n = '0;
      complete  = 1'b0;
`ifdef CM_ARB_TIMEOUT_EN
      wait_cnt_n    = wait_cnt;
      timeout_err_n = 1'b0;
`endif
      unique case (state)
         IDLE: begin
            if (pick_found) begin
               owner_n   = pick_idx;
               c_addr_n  = req_addr_arr[pick_idx];
               c_data_n  = req_data_arr[pick_idx];
               grant_n   = pick;
               c_valid_n = 1'b1;
               busy_n    = 1'b1;
               state_n   = ISSUE;
`ifdef CM_ARB_TIMEOUT_EN
               wait_cnt_n = '0;
`endif
            end
         end
         ISSUE: begin
            complete = C_Rdy;
`ifdef CM_ARB_TIMEOUT_EN
            // A ready in the expiry cycle wins: that is a normal completion.
            if (!C_Rdy) begin
               wait_cnt_n = wait_cnt + 1'b1;
               if (expired) begin
                  complete      = 1'b1;
                  timeout_err_n = 1'b1;
               end
            end
`endif
            if (complete) begin
               c_valid_n = 1'b0;
               req_rdy_n = Grant;
               last_n    = owner;
               state_n   = DONE;
            end
         end
         DONE: begin
            grant_n = '0;
            busy_n  = 1'b0;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // NOTE: registers use <= so every flop samples the pre-edge values of the others.
   always_ff @(posedge Clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         last    <= IDX_W'(NUM_REQ - 1);
         owner   <= '0;
         C_Addr  <= '0;
         C_Data  <= '0;
         C_Valid <= 1'b0;
         Req_Rdy <= '0;
         Grant   <= '0;
         Busy    <= 1'b0;
`ifdef CM_ARB_TIMEOUT_EN
         wait_cnt    <= '0;
         Timeout_Err <= 1'b0;
`endif
      end else begin
         state   <= state_n;
         last    <= last_n;
         owner   <= owner_n;
         C_Addr  <= c_addr_n;
         C_Data  <= c_data_n;
         C_Valid <= c_valid_n;
         Req_Rdy <= req_rdy_n;
         Grant   <= grant_n;
         Busy    <= busy_n;
`ifdef CM_ARB_TIMEOUT_EN
         wait_cnt    <= wait_cnt_n;
         Timeout_Err <= timeout_err_n;
`endif
      end
   end

endmodule

// File: doc/color_manager_config_arbiter.md
# color_manager_config_arbiter

Round-robin arbiter that shares the Color Manager configuration bus (C_Addr / C_Data / C_Valid / C_Rdy) between several configuration sources: the UART-driven config manager, a power-on default loader and future sources. It sits between the requesters and the UART/VGA configuration targets. It serialises one transfer at a time, holds the winner's word stable until the target accepts it, and then acknowledges the winner.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- C_ADDR_WIDTH, 4, config address width
- C_DATA_WIDTH, 14, config data width
- TIMEOUT_CYCLES, 255, max ISSUE cycles waiting for C_Rdy (used only with CM_ARB_TIMEOUT_EN)

Ports:
- Clk  in  1  clock; all logic on posedge
- rst_n  in  1  reset, synchronous, active-low
- Req_Valid  in  NUM_REQ  per-requester request, held until the matching Req_Rdy
- Req_Addr  in  NUM_REQ*C_ADDR_WIDTH  flattened addresses; requester i at [i*C_ADDR_WIDTH +: C_ADDR_WIDTH]
- Req_Data  in  NUM_REQ*C_DATA_WIDTH  flattened data, same packing
- Req_Rdy  out  NUM_REQ  one-cycle completion pulse to the granted requester
- C_Addr  out  C_ADDR_WIDTH  address to targets
- C_Data  out  C_DATA_WIDTH  data to targets
- C_Valid  out  1  transfer valid
- C_Rdy  in  1  target ready; a transfer completes in the cycle where C_Valid and C_Rdy are both 1
- Grant  out  NUM_REQ  one-hot current owner; zero when idle
- Busy  out  1  high outside IDLE
- Timeout_Err  out  1  one-cycle pulse on an abandoned transfer

## Operation
- All outputs are registered.
- Reset values: C_Addr=0, C_Data=0, C_Valid=0, Req_Rdy=0, Grant=0, Busy=0, Timeout_Err=0, state=IDLE, priority pointer Last=NUM_REQ-1, so requester 0 wins first.
- States:
  - IDLE: if any Req_Valid is set, pick the winner g, searching from Last+1 upward modulo NUM_REQ. Latch Req_Addr[g] and Req_Data[g] into C_Addr and C_Data. Set Grant=1<<g, C_Valid=1, Busy=1. Go to ISSUE. If no Req_Valid is set, stay in IDLE.
  - ISSUE: hold C_Valid, C_Addr, C_Data and Grant stable. If C_Rdy=1, clear C_Valid, pulse Req_Rdy[g], set Last=g and go to DONE. Otherwise stay in ISSUE.
  - DONE: clear Req_Rdy, clear Grant, clear Busy and go to IDLE. No arbitration happens in this state, so a Req_Valid still high during the acknowledge cycle is never re-granted.
- Latched word rule: C_Addr and C_Data are captured only on the IDLE→ISSUE edge. Later changes on Req_Addr or Req_Data, or a protocol-violating drop of Req_Valid during ISSUE, are ignored. The transfer completes with the latched word.
- Requesters that are not granted keep waiting; a pending request is never lost.
- Fairness: once served, a requester has the lowest priority until every other active requester has been served.
- C_Rdy is ignored outside ISSUE.
- Synchronous reset asserted mid-transfer aborts the transfer with no Req_Rdy. All outputs return to reset values on the next edge.

## Timing
- Request seen high in IDLE at cycle 0 → C_Valid=1 and Grant valid in cycle 1.
- C_Rdy=1 in cycle n (n≥1) → C_Valid=0 and Req_Rdy=1 in cycle n+1; Busy=0 and Grant=0 in cycle n+2.
- Earliest next grant is in cycle n+3. Minimum throughput is one transfer per 3 cycles.
- Requests arriving together in IDLE are resolved in the same cycle; exactly one requester is granted.

## Configuration
- CM_ARB_TIMEOUT_EN defined:
  - An 8-bit or wider counter clears on entering ISSUE and increments on every ISSUE cycle with C_Rdy=0.
  - When the counter reaches TIMEOUT_CYCLES, the arbiter clears C_Valid and pulses Timeout_Err and Req_Rdy[g] together for one cycle, sets Last=g and goes to DONE.
  - If C_Rdy=1 arrives in the same cycle as the counter expiry, it is a normal completion and Timeout_Err stays 0.
- CM_ARB_TIMEOUT_EN undefined: ISSUE waits indefinitely, Timeout_Err is tied to 0, and no counter is built.

## Structure
- Shared parameter include Color_Manager_Arb_Parameters.v, under PARAM alongside the other Color_Manager parameter files. It holds:
  - the state encodings IDLE, ISSUE and DONE, with ARB_STATE_WIDTH=2
  - the default TIMEOUT_CYCLES
- One sub-module, color_manager_rr_picker: combinational. Inputs are Req_Valid and Last; outputs are the one-hot winner and its index. It is instantiated once and is unit-testable on its own.

## Test plan
- Single request: Req_Valid=4'b0010, addr 4'h3, data 14'h155, C_Rdy=1 → C_Valid, C_Addr=3 and C_Data=14'h155 in cycle 1; Req_Rdy=4'b0010 in cycle 2; Busy=0 in cycle 3.
- All four requesters held high with C_Rdy=1 → grant order 0,1,2,3,0; one transfer every 3 cycles.
- Backpressure: C_Rdy=0 for 10 cycles, then 1 → C_Valid, C_Addr and C_Data stable for 11 cycles; exactly one Req_Rdy pulse.
- Req_Data changed to 14'h3FF during ISSUE → the target still receives the originally latched value.
- rst_n=0 in mid-ISSUE → the next cycle shows all outputs at reset values and no Req_Rdy; after release, requester 0 wins first.
- With CM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=5 and C_Rdy held at 0 → Timeout_Err and Req_Rdy pulse together after 5 ISSUE cycles, then the next requester is granted.
